// File: rtl/arb_pkg.sv
// Shared types and defaults for the round-robin grant arbiter.
// Optional feature macro: ARB_HOLD_LIMIT_EN (forced handover after MAX_HOLD cycles).
package arb_pkg;

    // Default number of requesters (width of request and grant).
    localparam int N_REQ_DEF = 2;

    // Default consecutive-grant limit, only meaningful with ARB_HOLD_LIMIT_EN.
    localparam int MAX_HOLD_DEF = 8;

    // Arbiter state: IDLE means grant is all-zero, BUSY means exactly one bit set.
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    // Request/grant vector for the default configuration.
    typedef logic [N_REQ_DEF-1:0] req_vec_t;

    // Width of an owner index; a single requester still needs one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_grant_arbiter_if.sv
// Request/grant interface between requesters (test side) and the arbiter.
// Handshake: request[i] is a level held by requester i for as long as it wants
// the resource; grant[i] is a registered level meaning requester i owns it.
// Ownership ends when the owner drops request[i]; the arbiter observes that at
// the next rising edge. grant is always one-hot or all-zero, busy == |grant,
// and grant_id is the owner index (0 when nobody owns the resource).
interface rr_grant_arbiter_if
    import arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF
) ();

    localparam int ID_W = id_width(N_REQ);

    logic [N_REQ-1:0] request;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_id;
    logic             busy;

    // Requester / test side: drives requests, watches grants.
    modport master (
        output request,
        input  grant,
        input  grant_id,
        input  busy
    );

    // Arbiter side: consumes requests, produces grants.
    modport slave (
        input  request,
        output grant,
        output grant_id,
        output busy
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit at or above ptr,
// wrapping around to the lowest set bit below ptr.
module rr_pick
    import arb_pkg::*;
#(
    parameter  int N_REQ = N_REQ_DEF,
    localparam int ID_W  = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] pick_oh,
    output logic [ID_W-1:0]  pick_idx,
    output logic             pick_any
);

    // Search: the wrap candidate (lowest set bit) is overridden by the lowest
    // set bit at or above ptr when one exists.
    always_comb begin
        int sel;
        sel      = 0;
        pick_any = 1'b0;
        pick_oh  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                sel      = i;
                pick_any = 1'b1;
            end
        end
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i] && (i >= int'(ptr))) begin
                sel = i;
            end
        end
        pick_idx = ID_W'(sel);
        for (int i = 0; i < N_REQ; i++) begin
            pick_oh[i] = pick_any && (i == sel);
        end
    end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with registered one-hot grant.
// The owner keeps the grant while it requests; on release the next requester
// (searching upward from the rotating pointer) takes over at the same edge.
// Optional feature macro: ARB_HOLD_LIMIT_EN -- after MAX_HOLD consecutive grant
// cycles the owner is forced to hand over if anybody else is waiting.
module rr_grant_arbiter
    import arb_pkg::*;
#(
    parameter  int N_REQ    = N_REQ_DEF,
    parameter  int MAX_HOLD = MAX_HOLD_DEF,
    localparam int ID_W     = id_width(N_REQ),
    localparam int HOLD_W   = $clog2(MAX_HOLD + 1)
) (
    input  logic                clk,
    input  logic                rst,
    rr_grant_arbiter_if.slave   bus,
    output arb_state_e          dbg_state,
    output logic [ID_W-1:0]     dbg_ptr,
    output logic [HOLD_W-1:0]   dbg_hold
);

    arb_state_e       state_q;
    logic [N_REQ-1:0] grant_q;
    logic [ID_W-1:0]  gid_q;
    logic             busy_q;
    logic [ID_W-1:0]  ptr_q;

    logic [N_REQ-1:0] others;
    logic [N_REQ-1:0] pick_oh;
    logic [ID_W-1:0]  pick_idx;
    logic             pick_any;
    logic [ID_W-1:0]  next_ptr;
    logic             owner_req;
    logic             force_ho;
    logic             keep;

    // Only non-owners compete; while busy, ptr already sits at owner+1 so the
    // search naturally visits the owner last.
    assign others    = bus.request & ~grant_q;
    assign owner_req = |(bus.request & grant_q);

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req      (others),
        .ptr      (ptr_q),
        .pick_oh  (pick_oh),
        .pick_idx (pick_idx),
        .pick_any (pick_any)
    );

    // Pointer moves one past the newly granted requester, wrapping to 0.
    assign next_ptr = (pick_idx == ID_W'(N_REQ - 1)) ? '0 : pick_idx + ID_W'(1);

`ifdef ARB_HOLD_LIMIT_EN
    logic [HOLD_W-1:0] hold_q;

    // Forced handover only when the owner is saturated and someone else waits.
    assign force_ho = (hold_q == HOLD_W'(MAX_HOLD)) && pick_any;

    // Consecutive-grant counter: 1 on a new grant, saturating while held.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
        end else if (keep) begin
            if (hold_q != HOLD_W'(MAX_HOLD)) begin
                hold_q <= hold_q + HOLD_W'(1);
            end
        end else if (pick_any) begin
            hold_q <= HOLD_W'(1);
        end else begin
            hold_q <= '0;
        end
    end

    assign dbg_hold = hold_q;
`else
    assign force_ho = 1'b0;
    assign dbg_hold = '0;
`endif

    // Owner retains the grant while it still requests and is not being evicted.
    assign keep = (state_q == ARB_BUSY) && owner_req && !force_ho;

    // Arbitration FSM with registered grant, owner index and busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            gid_q   <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= '0;
        end else if (keep) begin
            state_q <= ARB_BUSY;
        end else if (pick_any) begin
            state_q <= ARB_BUSY;
            grant_q <= pick_oh;
            gid_q   <= pick_idx;
            busy_q  <= 1'b1;
            ptr_q   <= next_ptr;
        end else begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            gid_q   <= '0;
            busy_q  <= 1'b0;
        end
    end

    assign bus.grant    = grant_q;
    assign bus.grant_id = gid_q;
    assign bus.busy     = busy_q;
    assign dbg_state    = state_q;
    assign dbg_ptr      = ptr_q;

endmodule
